// File: rtl/in_filt_bank.sv
// Bank of WIDTH input channels: 2-flop synchroniser, FILT_CYCLES glitch filter,
// registered per-channel selectable inversion. Optional sticky change flags under IN_FILT_STICKY_EN.
module in_filt_bank #(
  parameter  int WIDTH       = 4,
  parameter  int FILT_CYCLES = 4,
  localparam int CNT_W       = $clog2(FILT_CYCLES) + 1
) (
  input  logic             C,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] INV,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Q,
  output logic             CHG
`ifdef IN_FILT_STICKY_EN
  ,
  input  logic             CLR,
  output logic [WIDTH-1:0] STICKY
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] f_q, f_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    f_d   = f_q;
    upd_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (EN && (s2_q[i] != f_q[i])) begin
        if (cnt_q[i] == CNT_LAST) begin
          f_d[i]   = s2_q[i];
          upd_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge C) begin
    if (RST) begin
      s1_q  <= '0;
      s2_q  <= '0;
      f_q   <= '0;
      upd_q <= '0;
      Q     <= '1;
      CHG   <= 1'b0;
      // NOTE: the counter array is small per-channel state, so it is reset like any other register.
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q  <= A;
      s2_q  <= s1_q;
      f_q   <= f_d;
      upd_q <= upd_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      // Q follows the already-accepted level; the update flag is delayed so CHG lines up with Q.
      Q     <= f_q ^ INV;
      CHG   <= |upd_q;
    end
  end

`ifdef IN_FILT_STICKY_EN
  always_ff @(posedge C) begin
    if (RST) begin
      STICKY <= '0;
    end else begin
      // Set wins over clear on the same edge.
      STICKY <= (CLR ? '0 : STICKY) | upd_q;
    end
  end
`endif

endmodule

// File: tb/tb_in_filt_bank.sv
// Self-checking bench for in_filt_bank: directed scenarios plus randomized traffic,
// all compared against a run-length reference model. Honours IN_FILT_STICKY_EN.
module tb_in_filt_bank;

  localparam int W    = 4;
  localparam int FILT = 4;

  logic         C = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b1;
  logic         CLR = 1'b0;
  logic [W-1:0] INV = '1;
  logic [W-1:0] A = '0;
  logic [W-1:0] Q;
  logic         CHG;
`ifdef IN_FILT_STICKY_EN
  logic [W-1:0] STICKY;
`endif

  in_filt_bank #(.WIDTH(W), .FILT_CYCLES(FILT)) dut (
    .C(C), .RST(RST), .EN(EN), .INV(INV), .A(A), .Q(Q), .CHG(CHG)
`ifdef IN_FILT_STICKY_EN
    , .CLR(CLR), .STICKY(STICKY)
`endif
  );

  always #5 C = ~C;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a channel adopts a new level once FILT consecutive
  // enabled samples (A seen two edges late) disagree with the accepted level.
  logic [W-1:0] m_p0, m_p1, m_acc, m_upd_prev;
  logic [W-1:0] exp_q, exp_sticky;
  logic         exp_chg;
  int           m_run [W];

  task automatic model_step();
    logic [W-1:0] upd;
    if (RST) begin
      m_p0 = '0; m_p1 = '0; m_acc = '0; m_upd_prev = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      exp_q = '1; exp_chg = 1'b0; exp_sticky = '0;
    end else begin
      exp_q      = m_acc ^ INV;
      exp_chg    = |m_upd_prev;
      exp_sticky = (CLR ? '0 : exp_sticky) | m_upd_prev;
      upd = '0;
      for (int i = 0; i < W; i++) begin
        if (EN && (m_p1[i] != m_acc[i])) begin
          m_run[i]++;
          if (m_run[i] == FILT) begin
            m_acc[i] = m_p1[i];
            m_run[i] = 0;
            upd[i]   = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_p1 = m_p0;
      m_p0 = A;
      m_upd_prev = upd;
    end
  endtask

  task automatic tick();
    @(posedge C);
    model_step();
    #1;
    check("q", 32'(Q), 32'(exp_q));
    check("chg", 32'(CHG), 32'(exp_chg));
`ifdef IN_FILT_STICKY_EN
    check("sticky", 32'(STICKY), 32'(exp_sticky));
`endif
  endtask

  int           lat;
  int           pulses;
  logic [W-1:0] q_before;

  initial begin
    exp_sticky = '0;

    // Reset with INV all ones, then drop INV.
    RST = 1'b1; INV = '1;
    tick(); tick();
    check("rst_q", 32'(Q), 32'hF);
    check("rst_chg", 32'(CHG), 32'h0);
    RST = 1'b0; INV = '0;
    tick();
    check("inv_q", 32'(Q), 32'h0);
    check("inv_chg", 32'(CHG), 32'h0);

    // Latency of a single channel with inversion.
    INV = '1;
    tick();
    A[0] = 1'b1;
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (CHG) begin lat = e; break; end
    end
    check("lat", 32'(lat), 32'(2 + FILT));
    check("lat_q", 32'(Q), 32'hE);
    tick();
    check("lat_chg_1cyc", 32'(CHG), 32'h0);
`ifdef IN_FILT_STICKY_EN
    check("sticky_ch0", 32'(STICKY), 32'h1);
`endif

    // Glitch of FILT-1 samples on channel 1.
    q_before = Q;
    A[1] = 1'b1;
    for (int e = 0; e < FILT - 1; e++) tick();
    A[1] = 1'b0;
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (CHG) pulses++;
    end
    check("glitch_chg", 32'(pulses), 32'h0);
    check("glitch_q", 32'(Q), 32'(q_before));

    // Enable held low while channel 2 rises.
    EN = 1'b0;
    q_before = Q;
    A[2] = 1'b1;
    for (int e = 0; e < 10; e++) tick();
    check("en0_q", 32'(Q), 32'(q_before));
    EN = 1'b1;
    lat = -1;
    for (int e = 1; e < 20; e++) begin
      tick();
      if (Q[2] != q_before[2]) begin lat = e; break; end
    end
    check("en1_lat", 32'(lat), 32'(FILT + 1));

`ifdef IN_FILT_STICKY_EN
    // Channel 1 update coincides with CLR: set wins, old bits cleared.
    for (int e = 0; e < 4; e++) tick();
    A[1] = 1'b1;
    for (int e = 0; e < 2 + FILT; e++) tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("clr_chg", 32'(CHG), 32'h1);
    check("sticky_clr_set", 32'(STICKY), 32'h2);
`endif

    // Simultaneous rise on all channels from a clean reset.
    RST = 1'b1; A = '0; tick(); RST = 1'b0;
    INV = '0;
    tick();
    A = '1;
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (CHG) pulses++;
    end
    check("simul_pulses", 32'(pulses), 32'h1);
    check("simul_q", 32'(Q), 32'hF);

    // Reset in the middle of a falling transition's count.
    A = '0;
    for (int e = 0; e < 4; e++) tick();
    RST = 1'b1; tick(); RST = 1'b0;
    check("midrst_q", 32'(Q), 32'hF);
    check("midrst_chg", 32'(CHG), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 9) == 0) A[i] = ~A[i];
      EN  = ($urandom_range(0, 9) != 0);
      CLR = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) INV = W'($urandom);
      RST = ($urandom_range(0, 199) == 0);
      tick();
    end
    RST = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/in_filt_bank.md
Name: in_filt_bank

Overview:
- Parametrised, clocked successor to the single-bit library inverter: a bank of WIDTH channels.
- Each channel synchronises an asynchronous pad-side input, rejects glitches shorter than FILT_CYCLES samples, then drives a registered output with per-channel selectable inversion.
- Sits between raw digital inputs and core logic, replacing ad-hoc inverter plus flop chains.

Parameters:
- WIDTH, 4, number of independent channels (min 1).
- FILT_CYCLES, 4, consecutive stable samples required to accept a new level (min 1).
- CNT_W, $clog2(FILT_CYCLES)+1, filter counter width (derived, not overridden).

Ports:
- C  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  filter enable; 0 freezes the accepted levels.
- INV  input  WIDTH  per-channel polarity; 1 = invert (Q = !level), 0 = pass.
- A  input  WIDTH  asynchronous channel inputs.
- Q  output  WIDTH  registered, filtered, polarity-adjusted outputs.
- CHG  output  1  one-cycle pulse; some channel's accepted level changed.

Behaviour:
- Interface: one clock C; RST is synchronous and active-high. All state changes occur on the rising edge of C.
- Per-channel state:
  - s1, s2: two-flop synchroniser.
  - F: accepted level.
  - CNT: CNT_W bits.
- Reset: while RST=1 at an edge, the following clear on that edge:
  - s1 = s2 = F = 0, CNT = 0.
  - Q = {WIDTH{1'b1}}, i.e. the inverter of 0, regardless of INV.
  - CHG = 0.
  - RST asserted mid-filtering discards any partial count.
- Synchroniser: s1 <= A; s2 <= s1. Runs whenever RST=0, independent of EN.
- Filter, per channel, when EN=1:
  - s2 == F: CNT <= 0.
  - s2 != F and CNT == FILT_CYCLES-1: F <= s2, CNT <= 0, per-channel update flag set for this edge.
  - s2 != F otherwise: CNT <= CNT+1.
- Filter when EN=0: F held, CNT <= 0. No updates; a pending partial count is lost.
- Output: Q[i] <= INV[i] ? !F[i] : F[i] every non-reset edge. An INV change alone reaches Q one edge later and does not raise CHG.
- CHG <= OR of all per-channel update flags. It is high for exactly the one cycle in which the affected Q bits take their new value.
- Latency:
  - A changes and is first captured by s1 at edge k.
  - F updates at edge k+1+FILT_CYCLES; Q and CHG update at edge k+2+FILT_CYCLES.
  - FILT_CYCLES=4 gives 6 edges; FILT_CYCLES=1 gives 3 edges.
- Glitch rejection: if s2 returns to F before the count completes, CNT clears and Q is unchanged. A pulse of FILT_CYCLES-1 samples is never propagated.
- Simultaneous events: channels are independent. Several channels may update on the same edge, producing a single CHG pulse. A toggle of s2 away from F and back during counting restarts the count from 0.
- Counter never exceeds FILT_CYCLES-1; no wrap-around possible.

Optional Feature:
- Macro IN_FILT_STICKY_EN.
- Defined: adds input CLR (1 bit) and output STICKY (WIDTH bits).
  - STICKY[i] sets on the same edge CHG is driven for channel i's update.
  - STICKY clears on any edge with CLR=1; set wins if both occur on the same edge.
  - STICKY resets to 0.
- Not defined: CLR and STICKY do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, WIDTH=4, INV=4'b1111: RST high for 2 edges -> Q=4'b1111, CHG=0. Then INV=4'b0000 -> Q=4'b0000 one edge later, CHG stays 0.
- FILT_CYCLES=4, INV=1111, A[0] 0->1 first captured at edge k -> Q[0] falls to 0 at edge k+6, CHG high exactly at that edge only. Q[3:1] stay 1.
- Glitch: A[1] high for 3 cycles, then low -> Q[1] never changes, CHG never pulses, CNT back to 0.
- EN=0 while A[2] held high for 10 cycles -> Q[2] unchanged. EN=1 -> Q[2] updates 4+1 edges later (s2 already settled).
- Simultaneous: A[3:0] 0000->1111 on the same edge, INV=0000 -> Q=1111 on a single edge with a single one-cycle CHG. RST asserted at count 2 during a second transition -> all state cleared, Q=1111.
- With IN_FILT_STICKY_EN: channel 0 update -> STICKY=0001, persists. CLR on the same edge as a channel 1 update -> STICKY=0010.
